// File: rtl/function_unit_encoder.sv
// Serialises one write request into "setValue" + ID byte + N data bytes (LSB first).
// Latency: request accepted at cycle t, first byte valid at t+1; one byte/cycle when unstalled.
// Backpressure: io_cmd_ready=0 holds payload and state; io_req_ready=1 only while idle.
//
// Ports:
//   clk, reset            - clock (rising edge), asynchronous active-high reset
//   io_req_valid/ready    - request handshake; ready is high only in IDLE
//   io_req_payload_sel    - target 0=A, 1=B, 2=C, 3=invalid (consumed and dropped)
//   io_req_payload_data   - 48-bit value, byte0 = data[7:0]
//   io_cmd_valid/ready    - output byte handshake (valid and payload are registered)
//   io_cmd_payload        - output byte; holds its last value while idle
//   io_busy               - high while a frame is in progress
module function_unit_encoder #(
    parameter int BYTES_A = 1,
    parameter int BYTES_B = 4,
    parameter int BYTES_C = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_req_valid,
    output logic        io_req_ready,
    input  logic [1:0]  io_req_payload_sel,
    input  logic [47:0] io_req_payload_data,
    output logic        io_cmd_valid,
    input  logic        io_cmd_ready,
    output logic [7:0]  io_cmd_payload,
    output logic        io_busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_ID     = 2'd2,
        ST_DATA   = 2'd3
    } state_t;

    localparam logic [2:0] LEN_A = 3'(BYTES_A);
    localparam logic [2:0] LEN_B = 3'(BYTES_B);
    localparam logic [2:0] LEN_C = 3'(BYTES_C);

    // ASCII "setValue", index 0 sent first.
    function automatic logic [7:0] f_hdr_byte(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = 8'h73; // s
            3'd1:    b = 8'h65; // e
            3'd2:    b = 8'h74; // t
            3'd3:    b = 8'h56; // V
            3'd4:    b = 8'h61; // a
            3'd5:    b = 8'h6C; // l
            3'd6:    b = 8'h75; // u
            default: b = 8'h65; // e
        endcase
        return b;
    endfunction

    function automatic logic [7:0] f_id_byte(input logic [1:0] sel);
        logic [7:0] b;
        case (sel)
            2'd0:    b = 8'h41;
            2'd1:    b = 8'h42;
            default: b = 8'h43;
        endcase
        return b;
    endfunction

    function automatic logic [2:0] f_len(input logic [1:0] sel);
        logic [2:0] n;
        case (sel)
            2'd0:    n = LEN_A;
            2'd1:    n = LEN_B;
            default: n = LEN_C;
        endcase
        return n;
    endfunction

    function automatic logic [7:0] f_data_byte(input logic [47:0] d, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = d[7:0];
            3'd1:    b = d[15:8];
            3'd2:    b = d[23:16];
            3'd3:    b = d[31:24];
            3'd4:    b = d[39:32];
            3'd5:    b = d[47:40];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    state_t      r_state;
    logic [2:0]  r_hdr_cnt;
    logic [2:0]  r_dat_cnt;
    logic [1:0]  r_sel;
    logic [47:0] r_data;
    logic        r_cmd_valid;
    logic [7:0]  r_cmd_payload;

    state_t      w_state_nxt;
    logic [2:0]  w_hdr_cnt_nxt;
    logic [2:0]  w_dat_cnt_nxt;
    logic [1:0]  w_sel_nxt;
    logic [47:0] w_data_nxt;
    logic        w_cmd_valid_nxt;
    logic [7:0]  w_cmd_payload_nxt;
    logic        w_xfer;
    logic [2:0]  w_len;

    assign w_xfer = r_cmd_valid && io_cmd_ready;
    assign w_len  = f_len(r_sel);

    // Next-state logic. The payload for the following byte is computed here and
    // registered, so the output stays a flop and still advances every cycle.
    always_comb begin
        w_state_nxt       = r_state;
        w_hdr_cnt_nxt     = r_hdr_cnt;
        w_dat_cnt_nxt     = r_dat_cnt;
        w_sel_nxt         = r_sel;
        w_data_nxt        = r_data;
        w_cmd_valid_nxt   = r_cmd_valid;
        w_cmd_payload_nxt = r_cmd_payload;

        case (r_state)
            ST_IDLE: begin
                w_cmd_valid_nxt = 1'b0;
                // sel=3 is consumed by the handshake but produces nothing.
                if (io_req_valid && io_req_payload_sel != 2'd3) begin
                    w_sel_nxt         = io_req_payload_sel;
                    w_data_nxt        = io_req_payload_data;
                    w_state_nxt       = ST_HEADER;
                    w_hdr_cnt_nxt     = 3'd0;
                    w_dat_cnt_nxt     = 3'd0;
                    w_cmd_valid_nxt   = 1'b1;
                    w_cmd_payload_nxt = f_hdr_byte(3'd0);
                end
            end
            ST_HEADER: begin
                if (w_xfer) begin
                    if (r_hdr_cnt == 3'd7) begin
                        w_state_nxt       = ST_ID;
                        w_hdr_cnt_nxt     = 3'd0;
                        w_cmd_payload_nxt = f_id_byte(r_sel);
                    end else begin
                        w_hdr_cnt_nxt     = r_hdr_cnt + 3'd1;
                        w_cmd_payload_nxt = f_hdr_byte(r_hdr_cnt + 3'd1);
                    end
                end
            end
            ST_ID: begin
                if (w_xfer) begin
                    w_state_nxt       = ST_DATA;
                    w_dat_cnt_nxt     = 3'd0;
                    w_cmd_payload_nxt = f_data_byte(r_data, 3'd0);
                end
            end
            default: begin // ST_DATA
                if (w_xfer) begin
                    if (r_dat_cnt == w_len - 3'd1) begin
                        // Payload keeps the last data byte while idle.
                        w_state_nxt     = ST_IDLE;
                        w_dat_cnt_nxt   = 3'd0;
                        w_cmd_valid_nxt = 1'b0;
                    end else begin
                        w_dat_cnt_nxt     = r_dat_cnt + 3'd1;
                        w_cmd_payload_nxt = f_data_byte(r_data, r_dat_cnt + 3'd1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_hdr_cnt     <= 3'd0;
            r_dat_cnt     <= 3'd0;
            r_sel         <= 2'd0;
            r_data        <= 48'd0;
            r_cmd_valid   <= 1'b0;
            r_cmd_payload <= 8'h00;
        end else begin
            r_state       <= w_state_nxt;
            r_hdr_cnt     <= w_hdr_cnt_nxt;
            r_dat_cnt     <= w_dat_cnt_nxt;
            r_sel         <= w_sel_nxt;
            r_data        <= w_data_nxt;
            r_cmd_valid   <= w_cmd_valid_nxt;
            r_cmd_payload <= w_cmd_payload_nxt;
        end
    end

    assign io_req_ready   = (r_state == ST_IDLE);
    assign io_busy        = (r_state != ST_IDLE);
    assign io_cmd_valid   = r_cmd_valid;
    assign io_cmd_payload = r_cmd_payload;

endmodule

// File: tb/tb_function_unit_encoder.sv
// Scoreboard bench for function_unit_encoder: directed frames, stalls, drop, back-to-back,
// mid-frame reset, then randomized requests and sink backpressure.
// Expected bytes come from a frame model; a negedge monitor pops and compares.
module tb_function_unit_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        io_req_valid = 1'b0;
    logic        io_req_ready;
    logic [1:0]  io_req_payload_sel = 2'd0;
    logic [47:0] io_req_payload_data = 48'd0;
    logic        io_cmd_valid;
    logic        io_cmd_ready = 1'b1;
    logic [7:0]  io_cmd_payload;
    logic        io_busy;

    function_unit_encoder #(.BYTES_A(1), .BYTES_B(4), .BYTES_C(6)) dut (
        .clk                 (clk),
        .reset               (reset),
        .io_req_valid        (io_req_valid),
        .io_req_ready        (io_req_ready),
        .io_req_payload_sel  (io_req_payload_sel),
        .io_req_payload_data (io_req_payload_data),
        .io_cmd_valid        (io_cmd_valid),
        .io_cmd_ready        (io_cmd_ready),
        .io_cmd_payload      (io_cmd_payload),
        .io_busy             (io_busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ready_mode = 0;   // 0: always ready, 1: 1,0,0 pattern, 2: random
    logic [7:0] exp_q[$];
    int xfer_cyc[$];
    int acc_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference frame: "setValue", 'A'+sel, then N bytes of data LSB first.
    function automatic void model_frame(input logic [1:0] sel, input logic [47:0] data);
        string hdr = "setValue";
        int n;
        logic [47:0] d;
        if (sel == 2'd3) return;
        n = (sel == 2'd0) ? 1 : (sel == 2'd1) ? 4 : 6;
        for (int i = 0; i < 8; i++) exp_q.push_back(hdr[i]);
        exp_q.push_back(8'h41 + 8'(sel));
        d = data;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(d[7:0]);
            d = d >> 8;
        end
    endfunction

    // Sink ready generator.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       io_cmd_ready = 1'b1;
                1:       io_cmd_ready = (cyc % 3 == 0);
                default: io_cmd_ready = ($urandom_range(3) != 0);
            endcase
        end
    end

    // Monitor: accepts feed the model, transfers are compared, stalls must hold.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_payload = 8'h00;
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            chk("busy_vs_ready", io_req_ready, !io_busy);
            chk("valid_vs_busy", io_cmd_valid, io_busy);
            if (prev_stall) begin
                chk("stall_valid_held", io_cmd_valid, 1'b1);
                chk("stall_payload_held", io_cmd_payload, prev_payload);
            end
            if (io_req_valid && io_req_ready) begin
                acc_cyc = cyc;
                model_frame(io_req_payload_sel, io_req_payload_data);
            end
            if (io_cmd_valid && io_cmd_ready) begin
                xfer_cyc.push_back(cyc);
                chk("byte_expected", (exp_q.size() != 0), 1'b1);
                if (exp_q.size() != 0) chk("cmd_byte", io_cmd_payload, exp_q.pop_front());
            end
            prev_stall   = io_cmd_valid && !io_cmd_ready;
            prev_payload = io_cmd_payload;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic issue(input logic [1:0] sel, input logic [47:0] data);
        logic got = 1'b0;
        io_req_valid        = 1'b1;
        io_req_payload_sel  = sel;
        io_req_payload_data = data;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (io_req_ready) got = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("req_accepted", got, 1'b1);
        io_req_valid        = 1'b0;
        io_req_payload_sel  = 2'($urandom);
        io_req_payload_data = {16'($urandom), 32'($urandom)};
    endtask

    task automatic wait_idle();
        logic done = 1'b0;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge clk);
            if (!io_busy && exp_q.size() == 0) done = 1'b1;
        end
        chk("idle_reached", done, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", io_cmd_valid, 1'b0);
        chk("rst_payload", io_cmd_payload, 8'h00);
        chk("rst_busy", io_busy, 1'b0);
        chk("rst_req_ready", io_req_ready, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 1: A frame, 10 consecutive bytes starting the cycle after accept
        xfer_cyc.delete();
        issue(2'd0, 48'h5A);
        wait_idle();
        chk("a_len", xfer_cyc.size(), 10);
        chk("a_first_lat", xfer_cyc[0] - acc_cyc, 1);
        chk("a_contiguous", xfer_cyc[9] - xfer_cyc[0], 9);

        // 2: B frame
        xfer_cyc.delete();
        issue(2'd1, 48'hFFFF_1234_5678);
        wait_idle();
        chk("b_len", xfer_cyc.size(), 13);

        // 3: C frame under 1,0,0 sink pattern
        ready_mode = 1;
        xfer_cyc.delete();
        issue(2'd2, 48'hAABB_CCDD_EEFF);
        wait_idle();
        chk("c_len", xfer_cyc.size(), 15);
        ready_mode = 0;

        // 4: sel=3 dropped in one cycle, then A frames normally
        xfer_cyc.delete();
        issue(2'd3, 48'h1122_3344_5566);
        repeat (5) begin
            @(negedge clk);
            chk("drop_no_valid", io_cmd_valid, 1'b0);
        end
        chk("drop_no_bytes", xfer_cyc.size(), 0);
        @(posedge clk);
        #1;
        issue(2'd0, 48'h00C3);
        wait_idle();
        chk("after_drop_len", xfer_cyc.size(), 10);

        // 5: back-to-back A then B with valid held
        xfer_cyc.delete();
        issue(2'd0, 48'h77);
        issue(2'd1, 48'hCAFE_BABE);
        wait_idle();
        chk("b2b_len", xfer_cyc.size(), 23);
        chk("b2b_gap", xfer_cyc[10] - xfer_cyc[9], 2);

        // 6: reset during DATA of a C frame
        issue(2'd2, 48'h0102_0304_0506);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk("midrst_valid", io_cmd_valid, 1'b0);
        chk("midrst_busy", io_busy, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        xfer_cyc.delete();
        issue(2'd1, 48'h0BAD_F00D);
        wait_idle();
        chk("postrst_len", xfer_cyc.size(), 13);

        // Randomized requests and sink backpressure
        ready_mode = 2;
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(2)) @(posedge clk);
            #0;
            issue(2'($urandom), {16'($urandom), 32'($urandom)});
        end
        wait_idle();
        ready_mode = 0;
        n0 = exp_q.size();
        chk("queue_drained", n0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
